// File: rtl/sentinel_key_conditioner.sv
// -----------------------------------------------------------------------------
// sentinel_key_conditioner
//
// Conditions the raw key pad bus for the Sentinel lock core. The input is
// synchronised and debounced. Each newly settled non-zero byte is presented as
// a one-cycle strobe. Optional rate limiting blocks presentation for a fixed
// window after too many consecutive rejected attempts.
//
// Build option:
//   SENTINEL_LOCKOUT_EN  defined   -> fail counting, LOCKOUT state and timer built
//                        undefined -> locked_out/fail_count tied to 0, and
//                                     verify_fail behaves like verify_ok
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a synchronised value must hold to count as settled (>=2)
//   MAX_FAILS        consecutive rejects that trigger lockout (1..15)
//   LOCKOUT_CYCLES   lockout window length in clocks (>=1)
//
// Ports:
//   clk          single clock, posedge
//   rst          synchronous active-high reset
//   ena          design enable; 0 holds the debouncer and freezes the FSM/timer
//   key_in[7:0]  raw asynchronous key pad bus
//   verify_ok    lock core pulse, presented key accepted
//   verify_fail  lock core pulse, presented key rejected
//   key_out[7:0] last presented key, held between strobes
//   key_valid    one-cycle strobe, key_out carries a new key
//   locked_out   high throughout LOCKOUT
//   fail_count   consecutive rejects since last accept or lockout exit
// -----------------------------------------------------------------------------
module sentinel_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_FAILS       = 3,
  parameter int LOCKOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] key_in,
  input  logic       verify_ok,
  input  logic       verify_fail,
  output logic [7:0] key_out,
  output logic       key_valid,
  output logic       locked_out,
  output logic [3:0] fail_count
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || MAX_FAILS < 1 || MAX_FAILS > 15 || LOCKOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sentinel_key_conditioner: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_ACTIVE  = 2'd0,
    S_WAIT    = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  logic [7:0]    r_candidate;
  logic [7:0]    r_last;
  logic [7:0]    r_key_out;
  logic [CW-1:0] r_count;
  logic          r_key_valid;
  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_wait;
  logic [1:0]    w_wait_next;
  logic          w_settled;
  logic          w_present;
  logic          w_release;
  logic          w_lock_exit;

`ifdef SENTINEL_LOCKOUT_EN
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [3:0]    r_fail_count;
  logic [3:0]    w_fail_next;
  logic          r_locked;
`endif

  // Settled/present are evaluated on registered state; the strobe itself is
  // registered, so it appears one cycle after the counter saturates.
  assign w_settled = (r_count == CNT_MAX);
  assign w_present = w_settled && (r_candidate != 8'h00) && (r_candidate != r_last)
                     && (r_state == S_ACTIVE) && ena;
  // A settled zero byte is a key release: allows the same key to be re-presented.
  assign w_release = w_settled && (r_candidate == 8'h00);

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_lock_exit  = 1'b0;
`ifdef SENTINEL_LOCKOUT_EN
    w_fail_next  = r_fail_count;
    w_timer_next = r_timer;
`endif
    if (ena) begin
      case (r_state)
        S_ACTIVE: begin
          if (w_present) begin
            w_state_next = S_WAIT;
            w_wait_next  = 2'd0;
          end
        end
        S_WAIT: begin
`ifdef SENTINEL_LOCKOUT_EN
          // fail is checked first so a simultaneous ok/fail counts as a reject
          if (verify_fail) begin
            w_fail_next = r_fail_count + 4'd1;
            if (w_fail_next == 4'(MAX_FAILS)) begin
              w_state_next = S_LOCKOUT;
              w_timer_next = TW'(LOCKOUT_CYCLES - 1);
            end else begin
              w_state_next = S_ACTIVE;
            end
          end else if (verify_ok) begin
            w_fail_next  = 4'd0;
            w_state_next = S_ACTIVE;
          end else
`else
          if (verify_fail || verify_ok) begin
            w_state_next = S_ACTIVE;
          end else
`endif
          // no answer within four cycles: give up, count unchanged
          if (r_wait == 2'd3) begin
            w_state_next = S_ACTIVE;
          end else begin
            w_wait_next = r_wait + 2'd1;
          end
        end
`ifdef SENTINEL_LOCKOUT_EN
        S_LOCKOUT: begin
          if (r_timer == '0) begin
            w_state_next = S_ACTIVE;
            w_fail_next  = 4'd0;
            w_lock_exit  = 1'b1;
          end else begin
            w_timer_next = r_timer - 1'b1;
          end
        end
`endif
        default: w_state_next = S_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_ACTIVE;
      r_wait  <= 2'd0;
`ifdef SENTINEL_LOCKOUT_EN
      r_fail_count <= 4'd0;
      r_timer      <= '0;
      r_locked     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
`ifdef SENTINEL_LOCKOUT_EN
      r_fail_count <= w_fail_next;
      r_timer      <= w_timer_next;
      r_locked     <= (w_state_next == S_LOCKOUT);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 8'h00;
      r_sync2     <= 8'h00;
      r_candidate <= 8'h00;
      r_count     <= '0;
      r_last      <= 8'h00;
      r_key_out   <= 8'h00;
      r_key_valid <= 1'b0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      // While disabled the whole debouncer holds (candidate frozen, count 0),
      // so a key applied during ena=0 restarts its full settle on enable.
      if (!ena) begin
        r_count <= '0;
      end else if (r_sync2 != r_candidate) begin
        r_candidate <= r_sync2;
        r_count     <= '0;
      end else if (r_count != CNT_MAX) begin
        r_count <= r_count + 1'b1;
      end
      r_key_valid <= w_present;
      if (w_present) begin
        r_key_out <= r_candidate;
        r_last    <= r_candidate;
      end else if (w_release || w_lock_exit) begin
        r_last <= 8'h00;
      end
    end
  end

  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
`ifdef SENTINEL_LOCKOUT_EN
  assign locked_out = r_locked;
  assign fail_count = r_fail_count;
`else
  assign locked_out = 1'b0;
  assign fail_count = 4'd0;
`endif

endmodule
